// File: rtl/dmi_pkg.sv
// Shared DMI definitions: request op codes, response status codes and the
// transaction FSM state type (also used by the JTAG DTM side).
package dmi_pkg;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_ST_OK     = 2'd0,
        DMI_ST_FAILED = 2'd2,
        DMI_ST_BUSY   = 2'd3
    } dmi_status_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } dmi_state_e;

endpackage

// File: rtl/dmi_wb_bridge.sv
// DMI request -> single Wishbone classic cycle bridge with sticky error status,
// bus timeout and dmireset/dmihardreset handling.
module dmi_wb_bridge
    import dmi_pkg::*;
#(
    parameter int DMI_ABITS      = 7,
    parameter int DMI_DATAW      = 32,
    parameter int WB_ADDRW       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [DMI_ABITS-1:0]   req_addr_i,
    input  logic [DMI_DATAW-1:0]   req_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [1:0]             rsp_op_o,
    output logic [DMI_DATAW-1:0]   rsp_data_o,
    input  logic                   dmireset_i,
    input  logic                   dmihardreset_i,
    output logic [1:0]             dmistat_o,
    output logic [WB_ADDRW-1:0]    wb_adr_o,
    output logic [DMI_DATAW-1:0]   wb_dat_o,
    input  logic [DMI_DATAW-1:0]   wb_dat_i,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [DMI_DATAW/8-1:0] wb_sel_o,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    dmi_state_e           state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [WB_ADDRW-1:0]  adr_q, adr_d;
    logic [DMI_DATAW-1:0] dat_q, dat_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [1:0]           rsp_op_q, rsp_op_d;
    logic [DMI_DATAW-1:0] rsp_data_q, rsp_data_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_hit;
    logic                 set_err;

    // The timeout fires in the BUS cycle that completes TIMEOUT_CYCLES cycles of waiting.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_op_d    = rsp_op_q;
        rsp_data_d  = rsp_data_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        set_err     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid_i && ready_q) begin
                    ready_d    = 1'b0;
                    adr_d      = WB_ADDRW'({req_addr_i, 2'b00});
                    dat_d      = req_data_i;
                    we_d       = (req_op_i == DMI_OP_WRITE);
                    rsp_data_d = '0;
                    if (!sticky_q && (req_op_i == DMI_OP_READ || req_op_i == DMI_OP_WRITE)) begin
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_op_d    = sticky_q ? DMI_ST_FAILED : DMI_ST_OK;
                    end
                end
            end
            ST_BUS: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (wb_err_i || timeout_hit) begin
                    state_d     = ST_RSP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_op_d    = DMI_ST_FAILED;
                    rsp_data_d  = '0;
                    set_err     = 1'b1;
                end else if (wb_ack_i) begin
                    state_d     = ST_RSP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_op_d    = DMI_ST_OK;
                    rsp_data_d  = we_q ? '0 : wb_dat_i;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A bus error in the same cycle as dmireset keeps the sticky flag set.
        if (dmireset_i) sticky_d = 1'b0;
        if (set_err)    sticky_d = 1'b1;

        if (dmihardreset_i) begin
            state_d     = ST_IDLE;
            ready_d     = 1'b1;
            cyc_d       = 1'b0;
            we_d        = 1'b0;
            rsp_valid_d = 1'b0;
            rsp_op_d    = DMI_ST_OK;
            rsp_data_d  = '0;
            sticky_d    = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= DMI_ST_OK;
            rsp_data_q  <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_op_q    <= rsp_op_d;
            rsp_data_q  <= rsp_data_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_op_o    = rsp_op_q;
    assign rsp_data_o  = rsp_data_q;
    assign dmistat_o   = {sticky_q, 1'b0};
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = '1;

endmodule

// File: tb/tb_dmi_wb_bridge.sv
// Scoreboard bench for dmi_wb_bridge with a registered-ack Wishbone slave model.
module tb_dmi_wb_bridge;
    import dmi_pkg::*;

    localparam int TO = 8;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [6:0]  req_addr_i;
    logic [31:0] req_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [1:0]  rsp_op_o;
    logic [31:0] rsp_data_o;
    logic        dmireset_i;
    logic        dmihardreset_i;
    logic [1:0]  dmistat_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    int   checks   = 0;
    int   failures = 0;
    int   cycle_cnt = 0;
    int   slave_mode = 0;
    exp_t exp_q[$];
    logic [31:0] mem [0:127];

    dmi_wb_bridge #(
        .DMI_ABITS(7), .DMI_DATAW(32), .WB_ADDRW(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_op_o(rsp_op_o),
        .rsp_data_o(rsp_data_o), .dmireset_i(dmireset_i), .dmihardreset_i(dmihardreset_i),
        .dmistat_o(dmistat_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle_cnt++;

    // Slave: ack (or ack+err) registered one cycle after stb; mode 1 never answers.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
        end else begin
            wb_ack_i <= wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && slave_mode != 1;
            wb_err_i <= wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && slave_mode == 2;
        end
    end

    assign wb_dat_i = mem[wb_adr_o[8:2]];

    function automatic exp_t mk(input logic [1:0] op, input logic [31:0] d);
        exp_t e;
        e.op   = op;
        e.data = d;
        return e;
    endfunction

    task automatic start_req(input logic [1:0] op, input logic [6:0] addr,
                             input logic [31:0] data, output bit ok);
        int n = 0;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_data_i  = data;
        while (!req_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        ok = req_ready_o;
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout ready=%b required=1", req_ready_o);
        end else begin
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
    endtask

    // Runs one request; returns when rsp_valid is seen (after the handshake if rsp_ready_i=1).
    task automatic do_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                          output logic [1:0] got_op, output logic [31:0] got_data,
                          output int lat, output int stb_n, output int match_n);
        bit ok;
        lat = -1; stb_n = 0; match_n = 0;
        got_op = 2'bxx; got_data = 'x;
        start_req(op, addr, data, ok);
        if (ok) begin
            for (int c = 1; c < 40; c++) begin
                if (wb_stb_o) begin
                    stb_n++;
                    if (wb_cyc_o && wb_sel_o == 4'hF && wb_adr_o == {23'd0, addr, 2'b00} &&
                        wb_we_o == (op == DMI_OP_WRITE) && (op != DMI_OP_WRITE || wb_dat_o == data))
                        match_n++;
                end
                if (rsp_valid_o) begin
                    lat = c; got_op = rsp_op_o; got_data = rsp_data_o;
                    break;
                end
                @(posedge clk_i); #1;
            end
            if (lat < 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid_o);
            end else if (rsp_ready_i) begin
                @(posedge clk_i); #1;
            end
        end
    endtask

    task automatic pulse_dmireset();
        dmireset_i = 1'b1;
        @(posedge clk_i); #1;
        dmireset_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", req_ready_o); end
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin failures++; $display("[TB] FAIL reset_bus got=%b exp=000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
        checks++; if (rsp_valid_o !== 1'b0 || rsp_op_o !== 2'd0 || rsp_data_o !== 32'd0) begin failures++; $display("[TB] FAIL reset_rsp got=%b/%0d/%h exp=0/0/0", rsp_valid_o, rsp_op_o, rsp_data_o); end
        checks++; if (dmistat_o !== 2'd0) begin failures++; $display("[TB] FAIL reset_dmistat got=%0d exp=0", dmistat_o); end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_ready got=%b exp=1", req_ready_o); end
    endtask

    task automatic test_read();
        logic [1:0] o; logic [31:0] d; int lat, sn, mn; exp_t e;
        exp_q.push_back(mk(DMI_ST_OK, 32'h0040_0C82));
        do_txn(DMI_OP_READ, 7'h11, 32'd0, o, d, lat, sn, mn);
        e = exp_q.pop_front();
        checks++; if ({o, d} !== e) begin failures++; $display("[TB] FAIL read_rsp got=%0d/%h exp=%0d/%h", o, d, e.op, e.data); end
        checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL read_latency got=%0d exp=3", lat); end
        checks++; if (sn !== 2 || mn !== 2) begin failures++; $display("[TB] FAIL read_bus_cycles got=%0d/%0d exp=2/2", sn, mn); end
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL read_ready_after got=%b exp=1", req_ready_o); end
    endtask

    task automatic test_write();
        logic [1:0] o; logic [31:0] d; int lat, sn, mn; exp_t e;
        exp_q.push_back(mk(DMI_ST_OK, 32'd0));
        do_txn(DMI_OP_WRITE, 7'h10, 32'h0000_0001, o, d, lat, sn, mn);
        e = exp_q.pop_front();
        checks++; if ({o, d} !== e) begin failures++; $display("[TB] FAIL write_rsp got=%0d/%h exp=%0d/%h", o, d, e.op, e.data); end
        checks++; if (sn !== 2 || mn !== 2) begin failures++; $display("[TB] FAIL write_stb_cycles got=%0d/%0d exp=2/2", sn, mn); end
        checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL write_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_nop();
        logic [1:0] o; logic [31:0] d; int lat, sn, mn; exp_t e;
        logic [1:0] ops [2];
        ops[0] = DMI_OP_NOP;
        ops[1] = DMI_OP_RSVD;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(DMI_ST_OK, 32'd0));
            do_txn(ops[i], 7'h22, 32'hDEAD_BEEF, o, d, lat, sn, mn);
            e = exp_q.pop_front();
            checks++; if ({o, d} !== e) begin failures++; $display("[TB] FAIL nop_rsp op=%0d got=%0d/%h exp=%0d/%h", ops[i], o, d, e.op, e.data); end
            checks++; if (sn !== 0 || lat !== 1) begin failures++; $display("[TB] FAIL nop_direct op=%0d stb=%0d lat=%0d exp=0/1", ops[i], sn, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] o; logic [31:0] d; int lat, sn, mn, c0; exp_t e;
        c0 = cycle_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(DMI_ST_OK, mem[7'h30 + i]));
            do_txn(DMI_OP_READ, 7'(7'h30 + i), 32'd0, o, d, lat, sn, mn);
            e = exp_q.pop_front();
            checks++; if ({o, d} !== e) begin failures++; $display("[TB] FAIL b2b_rsp%0d got=%0d/%h exp=%0d/%h", i, o, d, e.op, e.data); end
        end
        checks++; if (cycle_cnt - c0 !== 12) begin failures++; $display("[TB] FAIL b2b_cycles got=%0d exp=12", cycle_cnt - c0); end
    endtask

    task automatic test_timeout();
        logic [1:0] o; logic [31:0] d; int lat, sn, mn; exp_t e;
        slave_mode = 1;
        exp_q.push_back(mk(DMI_ST_FAILED, 32'd0));
        do_txn(DMI_OP_READ, 7'h11, 32'd0, o, d, lat, sn, mn);
        e = exp_q.pop_front();
        checks++; if ({o, d} !== e) begin failures++; $display("[TB] FAIL timeout_rsp got=%0d/%h exp=%0d/%h", o, d, e.op, e.data); end
        checks++; if (sn !== TO) begin failures++; $display("[TB] FAIL timeout_stb_cycles got=%0d exp=%0d", sn, TO); end
        checks++; if (dmistat_o !== 2'd2) begin failures++; $display("[TB] FAIL timeout_dmistat got=%0d exp=2", dmistat_o); end
        slave_mode = 0;
        exp_q.push_back(mk(DMI_ST_FAILED, 32'd0));
        do_txn(DMI_OP_READ, 7'h11, 32'd0, o, d, lat, sn, mn);
        e = exp_q.pop_front();
        checks++; if ({o, d} !== e) begin failures++; $display("[TB] FAIL sticky_rsp got=%0d/%h exp=%0d/%h", o, d, e.op, e.data); end
        checks++; if (sn !== 0) begin failures++; $display("[TB] FAIL sticky_no_bus got=%0d exp=0", sn); end
        pulse_dmireset();
        checks++; if (dmistat_o !== 2'd0) begin failures++; $display("[TB] FAIL dmireset_clear got=%0d exp=0", dmistat_o); end
        exp_q.push_back(mk(DMI_ST_OK, 32'h0040_0C82));
        do_txn(DMI_OP_READ, 7'h11, 32'd0, o, d, lat, sn, mn);
        e = exp_q.pop_front();
        checks++; if ({o, d} !== e) begin failures++; $display("[TB] FAIL after_dmireset_rsp got=%0d/%h exp=%0d/%h", o, d, e.op, e.data); end
    endtask

    task automatic test_err_ack();
        logic [1:0] o; logic [31:0] d; int lat, sn, mn; exp_t e;
        slave_mode = 2;
        exp_q.push_back(mk(DMI_ST_FAILED, 32'd0));
        do_txn(DMI_OP_READ, 7'h05, 32'd0, o, d, lat, sn, mn);
        e = exp_q.pop_front();
        checks++; if ({o, d} !== e) begin failures++; $display("[TB] FAIL err_ack_rsp got=%0d/%h exp=%0d/%h", o, d, e.op, e.data); end
        checks++; if (dmistat_o !== 2'd2 || sn !== 2) begin failures++; $display("[TB] FAIL err_ack_sticky dmistat=%0d stb=%0d exp=2/2", dmistat_o, sn); end
        slave_mode = 0;
        pulse_dmireset();
    endtask

    task automatic test_rsp_hold();
        logic [1:0] o; logic [31:0] d; int lat, sn, mn, c0; exp_t e;
        rsp_ready_i = 1'b0;
        exp_q.push_back(mk(DMI_ST_OK, mem[7'h05]));
        do_txn(DMI_OP_READ, 7'h05, 32'd0, o, d, lat, sn, mn);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_op_o !== o || rsp_data_o !== d || req_ready_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_stable%0d got=%b/%0d/%h/%b exp=1/%0d/%h/0", i, rsp_valid_o, rsp_op_o, rsp_data_o, req_ready_o, o, d);
            end
        end
        rsp_ready_i = 1'b1;
        e = exp_q.pop_front();
        checks++; if ({o, d} !== e) begin failures++; $display("[TB] FAIL hold_rsp got=%0d/%h exp=%0d/%h", o, d, e.op, e.data); end
        @(posedge clk_i); #1;
        checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL hold_release got=%b/%b exp=1/0", req_ready_o, rsp_valid_o); end
        c0 = cycle_cnt;
        exp_q.push_back(mk(DMI_ST_OK, 32'd0));
        do_txn(DMI_OP_WRITE, 7'h12, 32'hCAFE_0123, o, d, lat, sn, mn);
        e = exp_q.pop_front();
        checks++; if ({o, d} !== e || cycle_cnt - c0 !== 4) begin failures++; $display("[TB] FAIL hold_next got=%0d/%h/%0d exp=%0d/%h/4", o, d, cycle_cnt - c0, e.op, e.data); end
    endtask

    task automatic test_reset_mid_bus();
        bit ok;
        slave_mode = 1;
        start_req(DMI_OP_READ, 7'h03, 32'd0, ok);
        checks++; if (wb_stb_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_stb got=%b exp=1", wb_stb_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o, dmistat_o} !== 5'd0) begin failures++; $display("[TB] FAIL rst_async got=%b exp=0", {wb_cyc_o, wb_stb_o, rsp_valid_o, dmistat_o}); end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        slave_mode = 0;
        @(posedge clk_i); #1;
        checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_recover got=%b/%b exp=1/0", req_ready_o, rsp_valid_o); end
    endtask

    task automatic test_hardreset();
        logic [1:0] o; logic [31:0] d; int lat, sn, mn; exp_t e; bit ok; bit seen;
        slave_mode = 1;
        start_req(DMI_OP_READ, 7'h03, 32'd0, ok);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        checks++; if (wb_stb_o !== 1'b1) begin failures++; $display("[TB] FAIL hrst_pre_stb got=%b exp=1", wb_stb_o); end
        dmihardreset_i = 1'b1;
        @(posedge clk_i); #1;
        dmihardreset_i = 1'b0;
        checks++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o, dmistat_o, req_ready_o} !== 6'b000001) begin failures++; $display("[TB] FAIL hrst_bus got=%b exp=000001", {wb_cyc_o, wb_stb_o, rsp_valid_o, dmistat_o, req_ready_o}); end
        slave_mode = 0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o || wb_cyc_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL hrst_discard got=%b exp=0", seen); end
        // Failed response parked in RSP with sticky set, then hard reset.
        slave_mode = 2;
        rsp_ready_i = 1'b0;
        do_txn(DMI_OP_READ, 7'h07, 32'd0, o, d, lat, sn, mn);
        checks++; if (dmistat_o !== 2'd2 || rsp_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL hrst_setup got=%0d/%b exp=2/1", dmistat_o, rsp_valid_o); end
        dmihardreset_i = 1'b1;
        @(posedge clk_i); #1;
        dmihardreset_i = 1'b0;
        rsp_ready_i = 1'b1;
        slave_mode = 0;
        checks++; if (rsp_valid_o !== 1'b0 || dmistat_o !== 2'd0) begin failures++; $display("[TB] FAIL hrst_rsp_sticky got=%b/%0d exp=0/0", rsp_valid_o, dmistat_o); end
        exp_q.push_back(mk(DMI_ST_OK, mem[7'h07]));
        do_txn(DMI_OP_READ, 7'h07, 32'd0, o, d, lat, sn, mn);
        e = exp_q.pop_front();
        checks++; if ({o, d} !== e) begin failures++; $display("[TB] FAIL hrst_after_rsp got=%0d/%h exp=%0d/%h", o, d, e.op, e.data); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | 32'(i * 32'h0101);
        mem[7'h11]     = 32'h0040_0C82;
        req_valid_i    = 1'b0;
        req_op_i       = 2'd0;
        req_addr_i     = 7'd0;
        req_data_i     = 32'd0;
        rsp_ready_i    = 1'b1;
        dmireset_i     = 1'b0;
        dmihardreset_i = 1'b0;
        rst_ni         = 1'b0;

        test_reset();
        test_read();
        test_write();
        test_nop();
        test_back_to_back();
        test_timeout();
        test_err_ack();
        test_rsp_hold();
        test_reset_mid_bus();
        test_hardreset();

        checks++; if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
